// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer controller: FSM state encoding
// and the default frame length.
package spi_pkg;

    localparam int NBITS_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/shiftreg16_out.sv
// Transmit shift register: parallel load, left shift on launch, MSB drives
// the serial line straight from a flop.
module shiftreg16_out
    import spi_pkg::*;
#(
    parameter int NBITS = NBITS_DEF
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             load,
    input  logic [NBITS-1:0] din,
    input  logic             shift,
    input  logic             clear,
    output logic             sout
);

    logic [NBITS-1:0] sr;

    // Clear wins so the line idles low whenever chip select is released.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sr <= '0;
        end else if (clear) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[NBITS-2:0], 1'b0};
        end
    end

    assign sout = sr[NBITS-1];

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master frame controller: sequences chip select, rate-generator enable
// and bit counting around an external rate generator and input shifter.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int NBITS = NBITS_DEF
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             abort,
    input  logic [NBITS-1:0] tx_data,
    input  logic             sampling,
    input  logic             update,
    input  logic [NBITS-1:0] rx_dout,
    output logic             en,
    output logic             sdout,
    output logic             cs_n,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] rx_data
);

    localparam int CW = $clog2(NBITS) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NBITS);
    localparam logic [CW-1:0] CNT_PRE  = CW'(NBITS - 1);

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic          sr_load;
    logic          sr_shift;
    logic          sr_clear;
    logic          in_frame;

    assign in_frame = (state == ST_SETUP) || (state == ST_XFER) || (state == ST_HOLD);

    // Bit 0 is launched during SETUP, so launches before the first capture are dropped.
    always_comb begin
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_clear = 1'b0;
        if (state == ST_IDLE && start) begin
            sr_load = 1'b1;
        end
        if ((in_frame && abort) || state == ST_HOLD) begin
            sr_clear = 1'b1;
        end
        if (state == ST_XFER && update && bit_cnt != '0 && bit_cnt != CNT_LAST) begin
            sr_shift = 1'b1;
        end
    end

    shiftreg16_out #(
        .NBITS (NBITS)
    ) u_tx_sr (
        .clk   (clk),
        .nrst  (nrst),
        .load  (sr_load),
        .din   (tx_data),
        .shift (sr_shift),
        .clear (sr_clear),
        .sout  (sdout)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            en      <= 1'b0;
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
        end else begin
            done <= 1'b0;
            if (in_frame && abort) begin
                state <= ST_IDLE;
                en    <= 1'b0;
                cs_n  <= 1'b1;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            bit_cnt <= '0;
                            cs_n    <= 1'b0;
                            busy    <= 1'b1;
                            state   <= ST_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        en    <= 1'b1;
                        state <= ST_XFER;
                    end
                    ST_XFER: begin
                        if (sampling) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == CNT_PRE) begin
                                en    <= 1'b0;
                                state <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        rx_data <= rx_dout;
                        done    <= 1'b1;
                        cs_n    <= 1'b1;
                        state   <= ST_DONE;
                    end
                    ST_DONE: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        en    <= 1'b0;
                        cs_n  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed-plus-random bench for spi_xfer_ctrl with a loopback input shifter.
module tb_spi_xfer_ctrl;

    localparam int NB = 16;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          sampling = 1'b0;
    logic          update = 1'b0;
    logic [NB-1:0] tx_data = '0;
    logic [NB-1:0] rx_dout;
    logic          en, sdout, cs_n, busy, done;
    logic [NB-1:0] rx_data;
    logic [NB-1:0] rx_sr = '0;

    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    spi_xfer_ctrl #(.NBITS(NB)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .start    (start),
        .abort    (abort),
        .tx_data  (tx_data),
        .sampling (sampling),
        .update   (update),
        .rx_dout  (rx_dout),
        .en       (en),
        .sdout    (sdout),
        .cs_n     (cs_n),
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data)
    );

    // Loopback input shift register: captures the serial line on each sampling strobe.
    assign rx_dout = rx_sr;
    always @(posedge clk) if (sampling) rx_sr <= {rx_sr[NB-2:0], sdout};
    always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_bit(input logic [NB-1:0] word, input int k);
        return logic'((word >> (NB - 1 - k)) & 1);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cs_n"}, 32'(cs_n), 32'd1);
        check({tag, "_en"},   32'(en),   32'd0);
        check({tag, "_sdout"},32'(sdout),32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic begin_frame(input logic [NB-1:0] word, input bit with_abort);
        tx_data = word;
        start = 1'b1;
        abort = with_abort;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tx_data = NB'($urandom);
        check("setup_cs_n",  32'(cs_n),  32'd0);
        check("setup_busy",  32'(busy),  32'd1);
        check("setup_en",    32'(en),    32'd0);
        check("setup_sdout", 32'(sdout), 32'(ref_bit(word, 0)));
        tick();
        check("xfer_en",   32'(en),   32'd1);
        check("xfer_cs_n", 32'(cs_n), 32'd0);
    endtask

    // dual: 0 separate strobes, 1 random merging, 2 always merged after the first bit
    task automatic run_bits(input logic [NB-1:0] word, input int n, input int dual,
                            input int restart_at, input bit early_update);
        bit merge;
        if (early_update) begin
            update = 1'b1;
            tick();
            update = 1'b0;
            check("upd_cnt0_ignored", 32'(sdout), 32'(ref_bit(word, 0)));
        end
        for (int k = 0; k < n; k++) begin
            check($sformatf("sdout_bit%0d", k), 32'(sdout), 32'(ref_bit(word, k)));
            check($sformatf("cs_low_bit%0d", k), 32'(cs_n), 32'd0);
            merge = (k >= 1) && (dual == 2 || (dual == 1 && $urandom_range(0, 1) == 1));
            sampling = 1'b1;
            update = merge;
            if (k == restart_at) begin
                start = 1'b1;
                tx_data = 16'hFFFF;
            end
            tick();
            sampling = 1'b0;
            update = 1'b0;
            start = 1'b0;
            if (k < n - 1) begin
                if (!merge) begin
                    repeat ($urandom_range(0, 2)) tick();
                    update = 1'b1;
                    tick();
                    update = 1'b0;
                end
                repeat ($urandom_range(0, 2)) tick();
            end
        end
    endtask

    task automatic finish_frame(input logic [NB-1:0] word, input bit start_in_done,
                                input logic [NB-1:0] next_word);
        int d0;
        check("hold_en",   32'(en),   32'd0);
        check("hold_cs_n", 32'(cs_n), 32'd0);
        check("hold_done", 32'(done), 32'd0);
        d0 = done_cnt;
        tick();
        check("done_pulse", 32'(done),    32'd1);
        check("done_cs_n",  32'(cs_n),    32'd1);
        check("done_sdout", 32'(sdout),   32'd0);
        check("done_busy",  32'(busy),    32'd1);
        check("rx_data",    32'(rx_data), 32'(word));
        if (start_in_done) begin
            start = 1'b1;
            tx_data = next_word;
        end
        tick();
        start = 1'b0;
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_cs_n", 32'(cs_n), 32'd1);
        check("one_done",  32'(done_cnt), 32'(d0 + 1));
    endtask

    initial begin
        logic [NB-1:0] w;
        int d0;

        // Reset values while nrst is held low
        #12;
        check_idle_outputs("reset");
        check("reset_rx_data", 32'(rx_data), 32'd0);
        @(posedge clk);
        #2;
        nrst = 1'b1;

        // First start right after reset release; start during DONE is ignored
        begin_frame(16'h8001, 1'b0);
        run_bits(16'h8001, NB, 0, -1, 1'b0);
        finish_frame(16'h8001, 1'b1, 16'h5A0F);

        // Start in the cycle after DONE is accepted; restart mid-frame is ignored
        begin_frame(16'h5A0F, 1'b0);
        run_bits(16'h5A0F, NB, 0, 5, 1'b0);
        finish_frame(16'h5A0F, 1'b0, '0);

        // Loopback of the reference word, with a launch strobe before the first capture
        begin_frame(16'hA5C3, 1'b0);
        run_bits(16'hA5C3, NB, 0, -1, 1'b1);
        finish_frame(16'hA5C3, 1'b0, '0);

        // Abort after five captured bits
        w = NB'($urandom);
        begin_frame(w, 1'b0);
        run_bits(w, 5, 1, -1, 1'b0);
        d0 = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle_outputs("abort");
        repeat (3) tick();
        check("abort_no_done", 32'(done_cnt), 32'(d0));
        check("abort_rx_keep", 32'(rx_data), 32'h0000A5C3);

        // Abort alone in IDLE does nothing; abort with start in IDLE is a start
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 32'd0);
        for (int f = 0; f < 3; f++) begin
            w = NB'($urandom);
            begin_frame(w, f == 0);
            run_bits(w, NB, 1, -1, 1'b0);
            finish_frame(w, 1'b0, '0);
        end

        // Capture and launch forced into the same cycle
        w = 16'hC35A;
        begin_frame(w, 1'b0);
        run_bits(w, NB, 2, -1, 1'b0);
        finish_frame(w, 1'b0, '0);

        // Asynchronous reset after eight bits
        w = NB'($urandom);
        begin_frame(w, 1'b0);
        run_bits(w, 8, 0, -1, 1'b0);
        d0 = done_cnt;
        #2;
        nrst = 1'b0;
        #1;
        check_idle_outputs("midrst");
        check("midrst_rx_data", 32'(rx_data), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) tick();
        check("midrst_no_done", 32'(done_cnt), 32'(d0));
        check("midrst_busy", 32'(busy), 32'd0);
        begin_frame(16'h1234, 1'b0);
        run_bits(16'h1234, NB, 1, -1, 1'b0);
        finish_frame(16'h1234, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 Parameter NBITS, default 16, frame length in bits.
REQ-002 clk  in  1  system clock; single clock domain, all logic on rising edge.
REQ-003 nrst  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  one-cycle request to begin a frame.
REQ-005 abort  in  1  terminate current frame immediately.
REQ-006 tx_data  in  NBITS  word to transmit, sampled on accepted start.
REQ-007 sampling  in  1  rate-generator strobe, one cycle, marks bit-capture instant.
REQ-008 update  in  1  rate-generator strobe, one cycle, marks bit-launch instant.
REQ-009 rx_dout  in  NBITS  parallel word from the input shift register.
REQ-010 en  out  1  rate-generator enable.
REQ-011 sdout  out  1  serial data out, MSB first.
REQ-012 cs_n  out  1  chip select, active-low.
REQ-013 busy  out  1  high from accepted start until return to IDLE.
REQ-014 done  out  1  one-cycle pulse on completed frame.
REQ-015 rx_data  out  NBITS  received word, held until next completed frame.

Function
REQ-016 FSM states IDLE, SETUP, XFER, HOLD, DONE; all outputs registered.
REQ-017 IDLE: cs_n=1, en=0, busy=0; start=1 latches tx_data into tx shift register, clears bit counter, moves to SETUP.
REQ-018 start in any state other than IDLE is ignored, including the DONE cycle.
REQ-019 SETUP lasts exactly one cycle: cs_n=0, sdout=tx_data[NBITS-1], en=0; then XFER.
REQ-020 XFER: en=1, cs_n=0; each sampling strobe increments bit counter (width clog2(NBITS)+1).
REQ-021 XFER: each update strobe shifts tx register left, sdout takes next bit; update is ignored once counter = NBITS or when counter = 0 (first bit already driven in SETUP).
REQ-022 sampling and update in the same cycle: both take effect.
REQ-023 Sampling strobe that brings counter to NBITS: en=0 next cycle, move to HOLD.
REQ-024 HOLD lasts one cycle: rx_data <= rx_dout; then DONE.
REQ-025 DONE lasts one cycle: done=1, cs_n=1, en=0; then IDLE.
REQ-026 abort=1 in SETUP, XFER or HOLD: next cycle IDLE, cs_n=1, en=0, busy=0, no done, rx_data unchanged; abort in IDLE/DONE has no effect.
REQ-027 abort and start in same cycle while IDLE: start accepted.
REQ-028 sdout=0 whenever cs_n=1.

Reset
REQ-029 nrst=0 forces asynchronously: state IDLE, cs_n=1, en=0, sdout=0, busy=0, done=0, rx_data=0, counter=0, tx register=0.
REQ-030 Reset mid-frame discards the frame; no done pulse after release.
REQ-031 First start is accepted in the first cycle after nrst deasserts.

Structure
REQ-032 Shared package spi_pkg holds state encoding and default NBITS constant.
REQ-033 Transmit path is a sub-module shiftreg16_out (parallel load, shift on update, serial out MSB first); FSM and counter remain in spi_xfer_ctrl.
REQ-034 Implementation sized 120-400 lines RTL; no latches, no combinational outputs.

Verification
REQ-035 Loopback sdout->sdin of input shift register, tx_data=16'hA5C3, start pulse -> 16 sampling strobes, rx_data=16'hA5C3, exactly one done pulse, cs_n low throughout.
REQ-036 tx_data=16'h8001 -> sdout first bit 1 in SETUP, bits 2-15 are 0, bit 16 is 1; en drops the cycle after the 16th sampling strobe.
REQ-037 start re-pulsed at bit 5 with tx_data=16'hFFFF -> ignored; frame completes with original word; start during DONE cycle ignored, start next cycle accepted.
REQ-038 abort after 5 sampling strobes -> next cycle cs_n=1, en=0, busy=0; no done; rx_data keeps prior 16'hA5C3.
REQ-039 nrst asserted after 8 bits -> all outputs at reset values immediately; no done after release; new frame 16'h1234 then completes correctly.
REQ-040 Forced same-cycle sampling+update -> both counted and shifted; received word still matches transmitted.
